syncore_tdp_ram_bytewr: RTL

Parametrised single-clock true-dual-port RAM with per-port byte-enable writes, per-port read-during-write mode, selectable read latency, deterministic write-collision resolution and a hardware clear engine. It is the next-generation storage primitive under the CPU and its buffers. It infers block RAM and adds the control behaviour the plain inferrer lacks: memory initialisation, read-valid tracking, collision flagging and out-of-range protection.

---
 rtl/syncore_tdp_ram_bytewr_if.sv | 29 ++
 rtl/syncore_tdp_ram_bytewr.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/syncore_tdp_ram_bytewr_if.sv
// syncore_tdp_ram_bytewr_if
// One RAM access port. The RAM instantiates two of these, one for port A and
// one for port B.
//   En      access request
//   We      write when En=1
//   ByteEn  per-lane write enables
//   Addr    word address
//   Din     write data
//   Dout    read data, held between Valid pulses
//   Valid   Dout carries a fresh read result
// The master modport drives the request side. The slave modport is the RAM side.
interface syncore_tdp_ram_bytewr_if #(
   parameter int DATAWIDTH = 32,
   parameter int BYTEWIDTH = 8,
   parameter int ADDRWIDTH = 10
) ();
   localparam int NBYTES = DATAWIDTH / BYTEWIDTH;

   logic                 En;
   logic                 We;
   logic [NBYTES-1:0]    ByteEn;
   logic [ADDRWIDTH-1:0] Addr;
   logic [DATAWIDTH-1:0] Din;
   logic [DATAWIDTH-1:0] Dout;
   logic                 Valid;

   modport master (output En, We, ByteEn, Addr, Din, input Dout, Valid);
   modport slave  (input En, We, ByteEn, Addr, Din, output Dout, Valid);
endinterface

// File: rtl/syncore_tdp_ram_bytewr.sv
// syncore_tdp_ram_bytewr
// Single-clock true-dual-port RAM. Each port supports byte-enable writes.
// Each port has its own read-during-write mode and its own read latency.
// When both ports write the same address, port A wins on its enabled lanes.
// A clear engine fills the array with INIT_VALUE.
// Ports:
//   PortClk     clock, rising edge
//   PortResetN  async active-low reset; resets control state, not memory contents
//   ClearReq    start a clear; ignored while Busy
//   Busy        clear engine owns the array; all port accesses are dropped
//   Collision   one-cycle pulse after both ports write the same word
//   port_a/b    access ports (syncore_tdp_ram_bytewr_if.slave)
//
// Clear FSM
//   state   | meaning
//   S_IDLE  | ports own the array
//   S_CLEAR | writing INIT_VALUE; clr_cnt_q counts words remaining
module syncore_tdp_ram_bytewr #(
   parameter int DATAWIDTH     = 32,
   parameter int BYTEWIDTH     = 8,
   parameter int ADDRWIDTH     = 10,
   parameter int MEMDEPTH      = 2**ADDRWIDTH,
   parameter int READ_MODE_A   = 1,
   parameter int READ_MODE_B   = 1,
   parameter int OUT_REG_A     = 1,
   parameter int OUT_REG_B     = 1,
   parameter int INIT_ON_RESET = 1,
   parameter logic [DATAWIDTH-1:0] INIT_VALUE = '0
) (
   input  logic PortClk,
   input  logic PortResetN,
   input  logic ClearReq,
   output logic Busy,
   output logic Collision,
   syncore_tdp_ram_bytewr_if.slave port_a,
   syncore_tdp_ram_bytewr_if.slave port_b
);
   localparam int NBYTES = DATAWIDTH / BYTEWIDTH;
   localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(MEMDEPTH - 1);

   typedef enum logic {S_IDLE, S_CLEAR} state_e;

   state_e               state_q, state_d;
   logic [ADDRWIDTH-1:0] clr_cnt_q, clr_cnt_d;
   logic [ADDRWIDTH-1:0] clr_addr;
   logic                 init_pend_q;
   logic                 collision_q, collision_d;

   logic [DATAWIDTH-1:0] mem_q [MEMDEPTH];

   logic [1:0]                 en, we, acc, wr, rd, in_rng;
   logic [1:0][NBYTES-1:0]     be;
   logic [1:0][ADDRWIDTH-1:0]  addr;
   logic [1:0][DATAWIDTH-1:0]  din, old, merged;

   assign en   = {port_b.En, port_a.En};
   assign we   = {port_b.We, port_a.We};
   assign be   = {port_b.ByteEn, port_a.ByteEn};
   assign addr = {port_b.Addr, port_a.Addr};
   assign din  = {port_b.Din, port_a.Din};

   // init_pend_q comes out of reset set when INIT_ON_RESET=1. It starts the
   // first clear on the first edge after release.
   always_ff @(posedge PortClk or negedge PortResetN) begin
      if (!PortResetN) begin
         state_q     <= S_IDLE;
         clr_cnt_q   <= '0;
         init_pend_q <= 1'(INIT_ON_RESET != 0);
         collision_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         init_pend_q <= 1'b0;
         collision_q <= collision_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (ClearReq || init_pend_q) begin
               state_d   = S_CLEAR;
               clr_cnt_d = LAST_ADDR;
            end
         end
         S_CLEAR: begin
            if (clr_cnt_q == '0) state_d = S_IDLE;
            else                 clr_cnt_d = clr_cnt_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The down-counter sweeps addresses upward from 0 to MEMDEPTH-1.
   always_comb begin
      Busy     = (state_q == S_CLEAR);
      clr_addr = LAST_ADDR - clr_cnt_q;
   end

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         acc[p]    = en[p] & ~Busy;
         wr[p]     = acc[p] & we[p] & (|be[p]);
         rd[p]     = acc[p] & ~we[p];
         in_rng[p] = ({1'b0, addr[p]} < (ADDRWIDTH+1)'(MEMDEPTH));
         old[p]    = in_rng[p] ? mem_q[addr[p]] : '0;
         for (int k = 0; k < NBYTES; k++)
            merged[p][k*BYTEWIDTH +: BYTEWIDTH] = be[p][k] ? din[p][k*BYTEWIDTH +: BYTEWIDTH]
                                                           : old[p][k*BYTEWIDTH +: BYTEWIDTH];
      end
      collision_d = wr[0] & wr[1] & in_rng[0] & in_rng[1] & (addr[0] == addr[1]);
   end

   // Port B is written first and port A second. On overlapping lanes the
   // later assignment (A) takes effect. Reads above see the pre-edge contents.
   always_ff @(posedge PortClk) begin
      if (Busy) begin
         mem_q[clr_addr] <= INIT_VALUE;
      end else begin
         for (int p = 1; p >= 0; p--) begin
            if (wr[p] && in_rng[p]) begin
               for (int k = 0; k < NBYTES; k++)
                  if (be[p][k])
                     mem_q[addr[p]][k*BYTEWIDTH +: BYTEWIDTH] <= din[p][k*BYTEWIDTH +: BYTEWIDTH];
            end
         end
      end
   end

   for (genvar p = 0; p < 2; p++) begin : g_port
      localparam int RMODE = (p == 0) ? READ_MODE_A : READ_MODE_B;
      localparam int OREG  = (p == 0) ? OUT_REG_A : OUT_REG_B;

      logic                 vld_s1, vld_fin, valid_q;
      logic [DATAWIDTH-1:0] data_s1, data_fin, dout_q;

      // A write reports on Dout unless the port is in no-change mode.
      assign vld_s1  = rd[p] | (wr[p] & (RMODE != 3));
      assign data_s1 = !in_rng[p] ? '0 :
                       ((wr[p] && RMODE == 2) ? merged[p] : old[p]);

      if (OREG != 0) begin : g_oreg
         logic                 pvld_q;
         logic [DATAWIDTH-1:0] pdata_q;
         always_ff @(posedge PortClk or negedge PortResetN) begin
            if (!PortResetN) begin
               pvld_q  <= 1'b0;
               pdata_q <= '0;
            end else begin
               pvld_q <= vld_s1;
               if (vld_s1) pdata_q <= data_s1;
            end
         end
         assign vld_fin  = pvld_q;
         assign data_fin = pdata_q;
      end else begin : g_noreg
         assign vld_fin  = vld_s1;
         assign data_fin = data_s1;
      end

      always_ff @(posedge PortClk or negedge PortResetN) begin
         if (!PortResetN) begin
            valid_q <= 1'b0;
            dout_q  <= '0;
         end else begin
            valid_q <= vld_fin;
            if (vld_fin) dout_q <= data_fin;
         end
      end
   end

   assign port_a.Dout  = g_port[0].dout_q;
   assign port_a.Valid = g_port[0].valid_q;
   assign port_b.Dout  = g_port[1].dout_q;
   assign port_b.Valid = g_port[1].valid_q;
   assign Collision    = collision_q;
endmodule
